// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears every register after reset, then round-robins the register file write port between ALU (A) and load (B) writeback.
// Define REGWR_ZERO_LOCK_EN to hardwire register 0 (transfers to it complete but never write).
module regfile_write_arbiter #(
  parameter int data_width = 16,
  parameter int address_width = 3,
  parameter int cnt_width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [address_width-1:0] a_addr,
  input  logic [data_width-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [address_width-1:0] b_addr,
  input  logic [data_width-1:0]    b_data,
  output logic                     b_ready,
  output logic                     rf_write_enable,
  output logic [address_width-1:0] rf_write_address,
  output logic [data_width-1:0]    rf_write_data,
  output logic                     init_busy,
  output logic                     last_grant,
  output logic [cnt_width-1:0]     conflict_count
);
  localparam logic [0:0] init_s = 1'b0;
  localparam logic [0:0] arb_s = 1'b1;
  logic [0:0] state;
  logic [address_width-1:0] ptr;
  logic [address_width-1:0] sel_addr;
  logic [data_width-1:0] sel_data;
  logic both, xfer, lock;
  assign init_busy = state == init_s;
  assign both = a_valid & b_valid;
  // On a conflict the requester that did not win last time gets the port.
  assign a_ready = !init_busy & a_valid & (!b_valid | last_grant);
  assign b_ready = !init_busy & b_valid & (!a_valid | !last_grant);
  assign xfer = a_ready | b_ready;
  assign sel_addr = a_ready ? a_addr : b_addr;
  assign sel_data = a_ready ? a_data : b_data;
`ifdef REGWR_ZERO_LOCK_EN
  assign lock = sel_addr == '0;
`else
  assign lock = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= init_s;
      ptr <= '0;
      rf_write_enable <= 1'b0;
      rf_write_address <= '0;
      rf_write_data <= '0;
      last_grant <= 1'b1;
      conflict_count <= '0;
    end else if (init_busy) begin
      rf_write_enable <= 1'b1;
      rf_write_address <= ptr;
      rf_write_data <= '0;
      ptr <= ptr + 1'b1;
      if (ptr == '1) state <= arb_s;
    end else begin
      rf_write_enable <= xfer & !lock;
      if (xfer & !lock) begin
        rf_write_address <= sel_addr;
        rf_write_data <= sel_data;
      end
      if (xfer) last_grant <= b_ready;
      if (both && conflict_count != '1) conflict_count <= conflict_count + 1'b1;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a cycle-level reference model.
module tb_regfile_write_arbiter;
  logic clk = 0, reset = 1, a_valid = 0, b_valid = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, rf_write_enable, init_busy, last_grant;
  logic [2:0] rf_write_address;
  logic [15:0] rf_write_data;
  logic [7:0] conflict_count;
  logic a_ready2, b_ready2, we2, busy2, last2;
  logic [2:0] addr2;
  logic [15:0] data2;
  logic [1:0] cc2;
  int total = 0, bad = 0;
  bit m_init, m_last, m_we, ea, eb;
  int m_ptr, m_cnt, m_cnt2, m_addr, m_data;
  logic [15:0] exp_mem[8], dut_mem[8];

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .init_busy(init_busy), .last_grant(last_grant),
    .conflict_count(conflict_count)
  );

  regfile_write_arbiter #(.cnt_width(2)) dut2 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready2),
    .rf_write_enable(we2), .rf_write_address(addr2),
    .rf_write_data(data2), .init_busy(busy2), .last_grant(last2),
    .conflict_count(cc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_ptr = 0; m_last = 1; m_cnt = 0; m_cnt2 = 0;
    m_we = 0; m_addr = 0; m_data = 0; ea = 0; eb = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we", rf_write_enable, 0);
    chk("rst_addr", rf_write_address, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_last", last_grant, 1);
    chk("rst_cnt", conflict_count, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    chk_reset_outputs();
    model_reset();
    #4;
    reset = 1;
  endtask

  task automatic cycle();
    int wa, wd;
    bit lock;
    #1;
    if (m_init) begin ea = 0; eb = 0; end
    else if (a_valid && b_valid) begin ea = m_last; eb = !m_last; end
    else begin ea = a_valid; eb = b_valid; end
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    if (m_init) begin
      m_we = 1; m_addr = m_ptr; m_data = 0; m_ptr++;
      if (m_ptr == 8) m_init = 0;
    end else begin
      m_we = 0;
      if (ea || eb) begin
        wa = ea ? a_addr : b_addr;
        wd = ea ? a_data : b_data;
`ifdef REGWR_ZERO_LOCK_EN
        lock = wa == 0;
`else
        lock = 0;
`endif
        if (!lock) begin m_we = 1; m_addr = wa; m_data = wd; end
        m_last = eb;
      end
      if (a_valid && b_valid) begin
        m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
        m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
      end
    end
    if (m_we) exp_mem[m_addr] = m_data[15:0];
    @(posedge clk);
    #1;
    if (rf_write_enable === 1'b1) dut_mem[rf_write_address] = rf_write_data;
    chk("we", rf_write_enable, m_we);
    if (m_we) begin
      chk("waddr", rf_write_address, m_addr);
      chk("wdata", rf_write_data, m_data);
    end
    chk("init_busy", init_busy, m_init);
    chk("last_grant", last_grant, m_last);
    chk("conflict_count", conflict_count, m_cnt);
    chk("conflict_count_sat", cc2, m_cnt2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin exp_mem[i] = 16'h5555; dut_mem[i] = 16'h5555; end
    #1 reset = 0;
    #1 chk_reset_outputs();
    model_reset();
    #20 reset = 1;
    for (int i = 0; i < 9; i++) cycle();
    chk("init_done", init_busy, 0);
    a_valid = 1; a_addr = 1; a_data = 16'hAAAA;
    b_valid = 1; b_addr = 2; b_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) cycle();
    chk("conflict4", conflict_count, 4);
    chk("conflict4_sat", cc2, 3);
    cycle();
    chk("conflict5_sat", cc2, 3);
    b_valid = 0;
    a_addr = 3; a_data = 16'h1234;
    cycle();
    a_valid = 0;
    cycle();
    a_valid = 1; a_addr = 0; a_data = 16'hFFFF;
    cycle();
    a_valid = 0;
    cycle();
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    a_valid = 1; a_addr = 5; a_data = 16'h00FF;
    do_reset();
    for (int i = 0; i < 8; i++) cycle();
    cycle();
    a_valid = 0;
    cycle();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      if (ea || !a_valid || $urandom_range(0, 7) == 0) begin
        a_valid = $urandom_range(0, 3) != 0; a_addr = 3'($urandom_range(0, 7)); a_data = 16'($urandom);
      end
      if (eb || !b_valid || $urandom_range(0, 7) == 0) begin
        b_valid = $urandom_range(0, 3) != 0; b_addr = 3'($urandom_range(0, 7)); b_data = 16'($urandom);
      end
      cycle();
    end
    a_valid = 0; b_valid = 0;
    cycle();
    for (int i = 0; i < 8; i++) chk($sformatf("mem%0d", i), dut_mem[i], exp_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
